regfile_wb: RTL and testbench
=============================

Name: regfile_wb

Overview:
- General-purpose register file of the MIPS core; receiving end of the write-back request produced by the memory stage (write address, write data, write enable).
- Holds 2^ADDR_W registers and commits one write per clock.
- Serves two independent combinational read ports to the decode stage.
- Same-cycle write-to-read bypass, so decode sees a value in the cycle it is being written back.

Parameters:
- ADDR_W, 5, register address width; register count = 2^ADDR_W.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  core clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- w_reg_addr  input  ADDR_W  write-back destination register.
- w_reg_data  input  DATA_W  write-back data.
- w_reg_en  input  1  write-back enable.
- r1_en  input  1  read port 1 enable.
- r1_addr  input  ADDR_W  read port 1 register address.
- r1_data  output  DATA_W  read port 1 data (combinational).
- r2_en  input  1  read port 2 enable.
- r2_addr  input  ADDR_W  read port 2 register address.
- r2_data  output  DATA_W  read port 2 data (combinational).

Behaviour:
- Reset:
  - rst_n low clears every storage register to 0 immediately, independent of clk.
  - While rst_n is low, r1_data = r2_data = 0 regardless of other inputs.
  - A write presented on an edge where rst_n is low is discarded.
- Write:
  - At the rising edge of clk with rst_n high and w_reg_en = 1: reg[w_reg_addr] <= w_reg_data.
  - Write latency is 1 cycle; visible in the array from the following cycle.
  - Writes to address 0 are ignored; reg[0] reads 0 at all times.
  - w_reg_en = 0: no state change, whatever w_reg_addr or w_reg_data hold.
- Read (each port independent, evaluated combinationally in this priority order):
  1. rst_n low -> 0.
  2. rN_en = 0 -> 0.
  3. rN_addr = 0 -> 0.
  4. w_reg_en = 1 and rN_addr = w_reg_addr -> w_reg_data (bypass; the write being committed this cycle).
  5. Otherwise -> reg[rN_addr].
- Simultaneous events:
  - Both ports may address the same register, including the one being written; both return identical data.
  - A bypass to address 0 is suppressed by rule 3.
- Widths:
  - No arithmetic; data is passed and stored unmodified at DATA_W bits.
  - Every address value 0..2^ADDR_W-1 is valid; there is no out-of-range case.
- Reset mid-operation:
  - Asserting rst_n between edges zeroes the array and outputs at once.
  - After deassertion, the first write commits on the first rising edge where rst_n is high and w_reg_en = 1.
- No stalls and no back-pressure: the block accepts one write every cycle.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, pulse rst_n low mid-cycle, release -> r1 reads r5 = 0 immediately during and after reset; no clk edge required.
- Basic write/read: write r3 = 0x12345678, next cycle r1_en = 1, r1_addr = 3 -> r1_data = 0x12345678; with r1_en = 0 -> r1_data = 0.
- Zero register: w_reg_en = 1, w_reg_addr = 0, w_reg_data = 0xFFFFFFFF, then read addr 0 on both ports in the same and the next cycle -> 0 on both ports.
- Bypass: r7 holds 0x1; in the same cycle w_reg_en = 1, w_reg_addr = 7, w_reg_data = 0xA5A5A5A5, r1_addr = r2_addr = 7 -> both ports 0xA5A5A5A5 that cycle; array holds 0xA5A5A5A5 next cycle.
- Enable gating: w_reg_en = 0, w_reg_addr = 9, w_reg_data = 0x55 over 3 edges -> r9 unchanged (0); no bypass while r1_addr = 9.
- Full sweep: write reg[i] = i*0x01010101 for i = 1..31, then read port 1 at i and port 2 at 31-i -> every value matches; port 2 returns 0 at i = 31 (address 0).

Source files
------------

// File: rtl/regfile_wb.sv
// MIPS general-purpose register file: one write-back port, two combinational
// read ports, with same-cycle bypass from the write being committed.
module regfile_wb #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] w_reg_addr,
  input  logic [DATA_W-1:0] w_reg_data,
  input  logic              w_reg_en,
  input  logic              r1_en,
  input  logic [ADDR_W-1:0] r1_addr,
  output logic [DATA_W-1:0] r1_data,
  input  logic              r2_en,
  input  logic [ADDR_W-1:0] r2_addr,
  output logic [DATA_W-1:0] r2_data
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic              wr_commit;

  // Entry 0 is never written, so it holds its reset value of zero forever.
  assign wr_commit = w_reg_en && (w_reg_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_commit) begin
      regs_q[w_reg_addr] <= w_reg_data;
    end
  end

  always_comb begin
    r1_data = '0;
    if (rst_n && r1_en && (r1_addr != '0)) begin
      if (w_reg_en && (r1_addr == w_reg_addr)) begin
        r1_data = w_reg_data;
      end else begin
        r1_data = regs_q[r1_addr];
      end
    end
  end

  always_comb begin
    r2_data = '0;
    if (rst_n && r2_en && (r2_addr != '0)) begin
      if (w_reg_en && (r2_addr == w_reg_addr)) begin
        r2_data = w_reg_data;
      end else begin
        r2_data = regs_q[r2_addr];
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed, table-driven bench for regfile_wb with hand-written sequences for
// asynchronous reset and the full register sweep.
module tb_regfile_wb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  w_reg_addr;
  logic [31:0] w_reg_data;
  logic        w_reg_en;
  logic        r1_en;
  logic [4:0]  r1_addr;
  logic [31:0] r1_data;
  logic        r2_en;
  logic [4:0]  r2_addr;
  logic [31:0] r2_data;

  int errors = 0;
  int checks = 0;

  regfile_wb #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .w_reg_addr (w_reg_addr),
    .w_reg_data (w_reg_data),
    .w_reg_en   (w_reg_en),
    .r1_en      (r1_en),
    .r1_addr    (r1_addr),
    .r1_data    (r1_data),
    .r2_en      (r2_en),
    .r2_addr    (r2_addr),
    .r2_data    (r2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst_n;
    logic        w_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        r1_en;
    logic [4:0]  r1_addr;
    logic        r2_en;
    logic [4:0]  r2_addr;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic e1, input logic [4:0] a1,
                       input logic e2, input logic [4:0] a2);
    w_reg_en   = we;
    w_reg_addr = wa;
    w_reg_data = wd;
    r1_en      = e1;
    r1_addr    = a1;
    r2_en      = e2;
    r2_addr    = a2;
  endtask

  initial begin
    // rst, we, waddr, wdata, r1en, r1a, r2en, r2a, exp1, exp2
    vecs[0]  = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 1'b1, 5'd5, 32'h0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 5'd3, 32'h12345678, 1'b1, 5'd3, 1'b1, 5'd5, 32'h12345678, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 1'b0, 5'd3, 32'h12345678, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0, 32'h0, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 1'b1, 5'd0, 32'h0, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 5'd7, 32'h00000001, 1'b1, 5'd7, 1'b0, 5'd7, 32'h1, 32'h0};
    vecs[6]  = '{1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7, 1'b1, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[7]  = '{1'b1, 1'b0, 5'd7, 32'h0,        1'b1, 5'd7, 1'b1, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[8]  = '{1'b1, 1'b0, 5'd9, 32'h00000055, 1'b1, 5'd9, 1'b1, 5'd9, 32'h0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 5'd9, 32'h00000055, 1'b1, 5'd9, 1'b1, 5'd9, 32'h0, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 5'd9, 32'h00000055, 1'b1, 5'd9, 1'b1, 5'd9, 32'h0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 32'h0};
    vecs[12] = '{1'b1, 1'b1, 5'd8, 32'hCAFEF00D, 1'b1, 5'd9, 1'b1, 5'd7, 32'h0, 32'hA5A5A5A5};

    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    repeat (2) @(posedge clk);
    #1;

    for (int v = 0; v < NVEC; v++) begin
      rst_n = vecs[v].rst_n;
      drive(vecs[v].w_en, vecs[v].w_addr, vecs[v].w_data,
            vecs[v].r1_en, vecs[v].r1_addr, vecs[v].r2_en, vecs[v].r2_addr);
      #1;
      check($sformatf("vec%0d_r1", v), r1_data, vecs[v].exp1);
      check($sformatf("vec%0d_r2", v), r2_data, vecs[v].exp2);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset between clock edges.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd7);
    #1;
    check("rst_pre_r5", r1_data, 32'hDEADBEEF);
    check("rst_pre_r7", r2_data, 32'hA5A5A5A5);
    rst_n = 1'b0;
    #1;
    check("rst_during_r5", r1_data, 32'h0);
    check("rst_during_r7", r2_data, 32'h0);
    rst_n = 1'b1;
    #1;
    check("rst_after_r5", r1_data, 32'h0);
    check("rst_after_r7", r2_data, 32'h0);
    check("rst_after_r3", dut.regs_q[3], 32'h0);

    // First write after reset release commits on the next edge.
    @(posedge clk);
    #1;
    drive(1'b1, 5'd4, 32'h00000044, 1'b0, 5'd0, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd8);
    #1;
    check("post_rst_r4", r1_data, 32'h00000044);
    check("post_rst_r8", r2_data, 32'h0);

    // Full sweep.
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i) * 32'h01010101, 1'b0, 5'd0, 1'b0, 5'd0);
      @(posedge clk);
      #1;
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    for (int i = 1; i < 32; i++) begin
      r1_en   = 1'b1;
      r1_addr = 5'(i);
      r2_en   = 1'b1;
      r2_addr = 5'(31 - i);
      #1;
      check($sformatf("sweep_r1_%0d", i), r1_data, 32'(i) * 32'h01010101);
      check($sformatf("sweep_r2_%0d", 31 - i), r2_data, 32'(31 - i) * 32'h01010101);
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
